// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: next-PC select encoding,
// the IF/ID bundle and the bubble instruction.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    PCSEL_PLUS4       = 2'b00,
    PCSEL_EXMEM_PLUS4 = 2'b01,
    PCSEL_BTB         = 2'b10,
    PCSEL_EXMEM_TGT   = 2'b11
  } pcsel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        btb_hit;
  } if_id_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones
// instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_o <= '0;
    else if (inc_i && !(&cnt_o))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/fetch_pc_stage.sv
// Fetch PC register, next-PC mux and IF/ID
// pipeline register with redirect/flush counters.
module fetch_pc_stage #(
  parameter int          INDEX_WIDTH = 12,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = fetch_pkg::NOP_INSTR,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [1:0]                IF_PCnext_sel_i,
  input  logic                      IF_flush_i,
  input  logic                      IF_btb_hit_i,
  input  logic [31:0]               IF_btb_target_i,
  input  logic [31:0]               EXMEM_PCplus4_i,
  input  logic [31:0]               EXMEM_br_target_i,
  input  logic                      ID_stall_i,
  input  logic [31:0]               imem_rdata_i,
  input  logic                      imem_ready_i,
  output logic [31:0]               imem_addr_o,
  output logic [31:0]               IF_PC_o,
  output logic [32-INDEX_WIDTH-3:0] IF_PC_tag_o,
  output logic [INDEX_WIDTH-1:0]    IF_btb_rd_index_o,
  output logic                      ID_valid_o,
  output logic [31:0]               ID_instr_o,
  output logic [31:0]               ID_PC_o,
  output logic [31:0]               ID_PCplus4_o,
  output logic                      ID_btb_hit_o,
  output logic [CNT_WIDTH-1:0]      redirect_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  import fetch_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] pc_sel;
  logic [31:0] pc_next;
  logic        accept;
  logic        redirect_inc;
  if_id_t      id_q;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = imem_ready_i & ~ID_stall_i & ~IF_flush_i;

  always_comb begin
    pc_sel = pc_plus4;
    unique case (pcsel_e'(IF_PCnext_sel_i))
      PCSEL_PLUS4:       pc_sel = pc_plus4;
      PCSEL_EXMEM_PLUS4: pc_sel = EXMEM_PCplus4_i;
      PCSEL_BTB:         pc_sel = IF_btb_target_i;
      PCSEL_EXMEM_TGT:   pc_sel = EXMEM_br_target_i;
    endcase
  end

  assign pc_next      = {pc_sel[31:2], 2'b00};
  assign redirect_inc = accept &
                        (IF_PCnext_sel_i == PCSEL_BTB);

  // Bubbles keep the old pc fields; only valid/instr/hit matter downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      id_q.valid   <= 1'b0;
      id_q.instr   <= NOP_INSTR;
      id_q.pc      <= '0;
      id_q.pcplus4 <= '0;
      id_q.btb_hit <= 1'b0;
    end else if (IF_flush_i) begin
      pc_q         <= pc_next;
      id_q.valid   <= 1'b0;
      id_q.instr   <= NOP_INSTR;
      id_q.btb_hit <= 1'b0;
    end else if (ID_stall_i) begin
      pc_q <= pc_q;
      id_q <= id_q;
    end else if (!imem_ready_i) begin
      id_q.valid   <= 1'b0;
      id_q.instr   <= NOP_INSTR;
      id_q.btb_hit <= 1'b0;
    end else begin
      pc_q         <= pc_next;
      id_q.valid   <= 1'b1;
      id_q.instr   <= imem_rdata_i;
      id_q.pc      <= pc_q;
      id_q.pcplus4 <= pc_plus4;
      id_q.btb_hit <= IF_btb_hit_i;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (redirect_inc),
    .cnt_o (redirect_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IF_flush_i),
    .cnt_o (flush_cnt_o)
  );

  assign IF_PC_o           = pc_q;
  assign imem_addr_o       = pc_q;
  assign IF_PC_tag_o       = pc_q[31:INDEX_WIDTH+2];
  assign IF_btb_rd_index_o = pc_q[INDEX_WIDTH+1:2];
  assign ID_valid_o        = id_q.valid;
  assign ID_instr_o        = id_q.instr;
  assign ID_PC_o           = id_q.pc;
  assign ID_PCplus4_o      = id_q.pcplus4;
  assign ID_btb_hit_o      = id_q.btb_hit;

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Directed + random bench for fetch_pc_stage
// against a rule-level reference model.
module tb_fetch_pc_stage;

  localparam int IW    = 12;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [1:0]        IF_PCnext_sel_i;
  logic              IF_flush_i;
  logic              IF_btb_hit_i;
  logic [31:0]       IF_btb_target_i;
  logic [31:0]       EXMEM_PCplus4_i;
  logic [31:0]       EXMEM_br_target_i;
  logic              ID_stall_i;
  logic [31:0]       imem_rdata_i;
  logic              imem_ready_i;
  logic [31:0]       imem_addr_o;
  logic [31:0]       IF_PC_o;
  logic [32-IW-3:0]  IF_PC_tag_o;
  logic [IW-1:0]     IF_btb_rd_index_o;
  logic              ID_valid_o;
  logic [31:0]       ID_instr_o;
  logic [31:0]       ID_PC_o;
  logic [31:0]       ID_PCplus4_o;
  logic              ID_btb_hit_o;
  logic [CW-1:0]     redirect_cnt_o;
  logic [CW-1:0]     flush_cnt_o;

  fetch_pc_stage #(
    .INDEX_WIDTH (IW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .IF_PCnext_sel_i   (IF_PCnext_sel_i),
    .IF_flush_i        (IF_flush_i),
    .IF_btb_hit_i      (IF_btb_hit_i),
    .IF_btb_target_i   (IF_btb_target_i),
    .EXMEM_PCplus4_i   (EXMEM_PCplus4_i),
    .EXMEM_br_target_i (EXMEM_br_target_i),
    .ID_stall_i        (ID_stall_i),
    .imem_rdata_i      (imem_rdata_i),
    .imem_ready_i      (imem_ready_i),
    .imem_addr_o       (imem_addr_o),
    .IF_PC_o           (IF_PC_o),
    .IF_PC_tag_o       (IF_PC_tag_o),
    .IF_btb_rd_index_o (IF_btb_rd_index_o),
    .ID_valid_o        (ID_valid_o),
    .ID_instr_o        (ID_instr_o),
    .ID_PC_o           (ID_PC_o),
    .ID_PCplus4_o      (ID_PCplus4_o),
    .ID_btb_hit_o      (ID_btb_hit_o),
    .redirect_cnt_o    (redirect_cnt_o),
    .flush_cnt_o       (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idp4;
  logic        m_hit;
  int          m_rc;
  int          m_fc;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Fetch-stage rules applied to the inputs present at the clock edge
  task automatic model_step();
    logic [31:0] cand [4];
    logic [31:0] nxt;
    cand[0] = m_pc + 32'd4;
    cand[1] = EXMEM_PCplus4_i;
    cand[2] = IF_btb_target_i;
    cand[3] = EXMEM_br_target_i;
    nxt = cand[IF_PCnext_sel_i] & 32'hFFFF_FFFC;
    if (rst_i) begin
      m_pc = 0; m_valid = 0; m_instr = NOP;
      m_idpc = 0; m_idp4 = 0; m_hit = 0;
      m_rc = 0; m_fc = 0;
    end else if (IF_flush_i) begin
      m_pc = nxt; m_valid = 0; m_instr = NOP; m_hit = 0;
      if (m_fc < CMAX) m_fc++;
    end else if (ID_stall_i) begin
    end else if (!imem_ready_i) begin
      m_valid = 0; m_instr = NOP; m_hit = 0;
    end else begin
      m_idpc = m_pc; m_idp4 = m_pc + 32'd4;
      m_valid = 1; m_instr = imem_rdata_i; m_hit = IF_btb_hit_i;
      if (IF_PCnext_sel_i == 2'd2 && m_rc < CMAX) m_rc++;
      m_pc = nxt;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    IF_PC_o, m_pc);
    check({tag, ".addr"},  imem_addr_o, m_pc);
    check({tag, ".tag"},   32'(IF_PC_tag_o), m_pc >> (IW + 2));
    check({tag, ".idx"},   32'(IF_btb_rd_index_o),
          (m_pc >> 2) % (32'd1 << IW));
    check({tag, ".valid"}, 32'(ID_valid_o), 32'(m_valid));
    check({tag, ".instr"}, ID_instr_o, m_instr);
    check({tag, ".hit"},   32'(ID_btb_hit_o), 32'(m_hit));
    if (m_valid) begin
      check({tag, ".idpc"}, ID_PC_o, m_idpc);
      check({tag, ".idp4"}, ID_PCplus4_o, m_idp4);
    end
    check({tag, ".rcnt"},  32'(redirect_cnt_o), 32'(m_rc));
    check({tag, ".fcnt"},  32'(flush_cnt_o), 32'(m_fc));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst_i = 0; IF_PCnext_sel_i = 0; IF_flush_i = 0;
    IF_btb_hit_i = 0; IF_btb_target_i = 0;
    EXMEM_PCplus4_i = 0; EXMEM_br_target_i = 0;
    ID_stall_i = 0; imem_rdata_i = 0; imem_ready_i = 1;
  endtask

  task automatic do_flush(input logic [31:0] tgt, input string tag);
    IF_flush_i = 1; IF_PCnext_sel_i = 2'd1; EXMEM_PCplus4_i = tgt;
    step(tag);
    idle();
  endtask

  initial begin
    m_pc = 0; m_valid = 0; m_instr = NOP;
    m_idpc = 0; m_idp4 = 0; m_hit = 0; m_rc = 0; m_fc = 0;
    idle();
    rst_i = 1;
    @(negedge clk_i);
    step("reset");
    rst_i = 0;

    imem_rdata_i = 32'hA; step("seq0");
    check("seq0.pc4", IF_PC_o, 32'h4);
    imem_rdata_i = 32'hB; step("seq1");
    imem_rdata_i = 32'hC; step("seq2");
    check("seq2.pcC", IF_PC_o, 32'hC);
    check("seq2.idC", ID_instr_o, 32'hC);
    imem_rdata_i = 32'hD; step("seq3");

    IF_PCnext_sel_i = 2'd2; IF_btb_hit_i = 1;
    IF_btb_target_i = 32'h200; imem_rdata_i = 32'h11;
    step("btb");
    check("btb.pc200", IF_PC_o, 32'h200);
    check("btb.idpc10", ID_PC_o, 32'h10);
    idle();

    IF_flush_i = 1; ID_stall_i = 1; IF_PCnext_sel_i = 2'd3;
    EXMEM_br_target_i = 32'h400; imem_rdata_i = 32'h55;
    step("flush_stall");
    check("flush_stall.pc400", IF_PC_o, 32'h400);
    idle();

    do_flush(32'h1C, "fl1c");
    imem_rdata_i = 32'h77; step("pre_stall");
    ID_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata_i = $urandom; step("stall");
    end
    check("stall.pc20", IF_PC_o, 32'h20);
    ID_stall_i = 0; imem_rdata_i = 32'h88; step("release");
    check("release.pc24", IF_PC_o, 32'h24);

    do_flush(32'h30, "fl30");
    imem_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      imem_rdata_i = $urandom; step("wait");
    end
    imem_ready_i = 1; imem_rdata_i = 32'h99; step("wait_done");
    check("wait_done.idpc", ID_PC_o, 32'h30);

    do_flush(32'hFFFF_FFFC, "flwrap");
    imem_rdata_i = 32'h42; step("wrap");
    check("wrap.pc0", IF_PC_o, 32'h0);

    IF_PCnext_sel_i = 2'd2; IF_btb_target_i = 32'h203;
    step("align");
    check("align.pc200", IF_PC_o, 32'h200);
    idle();

    for (int i = 0; i < 400; i++) begin
      rst_i             = ($urandom_range(0, 59) == 0);
      IF_flush_i        = ($urandom_range(0, 7) == 0);
      ID_stall_i        = ($urandom_range(0, 4) == 0);
      imem_ready_i      = ($urandom_range(0, 3) != 0);
      IF_btb_hit_i      = $urandom_range(0, 1);
      IF_PCnext_sel_i   = IF_flush_i ? {$urandom_range(0, 1) == 1, 1'b1}
                                     : 2'($urandom_range(0, 3));
      IF_btb_target_i   = $urandom;
      EXMEM_PCplus4_i   = $urandom;
      EXMEM_br_target_i = $urandom;
      imem_rdata_i      = $urandom;
      step("rand");
    end
    idle();

    IF_flush_i = 1; IF_PCnext_sel_i = 2'd3;
    for (int i = 0; i < (1 << CW) + 3; i++) begin
      EXMEM_br_target_i = $urandom;
      model_step();
      @(posedge clk_i);
    end
    #1;
    check_all("sat");
    check("sat.ones", 32'(flush_cnt_o), 32'(CMAX));
    idle();

    imem_rdata_i = 32'h5; step("pre_rst");
    ID_stall_i = 1; rst_i = 1;
    step("rst_stall");
    check("rst_stall.valid", 32'(ID_valid_o), 32'h0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- Fetch-stage front end that owns the architectural fetch PC and produces the IF/ID pipeline register.
- Consumes the branch predictor's next-PC select, BTB target and flush outputs.
- Drives the predictor's IF tag/index fields, applies hazard stalls and instruction-memory wait states.
- Keeps saturating performance counters for redirects and flushes.

Parameters:
- INDEX_WIDTH, 12, BTB index width; tag width is 32-INDEX_WIDTH-2.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction injected into ID on bubble/flush (addi x0,x0,0).
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- IF_PCnext_sel_i  in  2  next-PC select: 00 IF_PC+4, 01 EXMEM_PCplus4, 10 IF_btb_target, 11 EXMEM_br_target
- IF_flush_i  in  1  misprediction flush from predictor
- IF_btb_hit_i  in  1  BTB hit for current fetch PC
- IF_btb_target_i  in  32  BTB predicted target
- EXMEM_PCplus4_i  in  32  recovery address, not-taken
- EXMEM_br_target_i  in  32  recovery address, taken
- ID_stall_i  in  1  hazard-unit stall (hold PC and IF/ID)
- imem_rdata_i  in  32  instruction at imem_addr_o (combinational read)
- imem_ready_i  in  1  imem_rdata_i valid this cycle
- imem_addr_o  out  32  equals IF_PC_o
- IF_PC_o  out  32  current fetch PC
- IF_PC_tag_o  out  32-INDEX_WIDTH-2  IF_PC_o[31:INDEX_WIDTH+2]
- IF_btb_rd_index_o  out  INDEX_WIDTH  IF_PC_o[INDEX_WIDTH+1:2]
- ID_valid_o  out  1  IF/ID holds a real instruction
- ID_instr_o  out  32  instruction
- ID_PC_o  out  32  PC of instruction
- ID_PCplus4_o  out  32  ID_PC_o+4
- ID_btb_hit_o  out  1  BTB hit recorded at fetch (forwarded to EXMEM_btb_hit)
- redirect_cnt_o  out  CNT_WIDTH  count of BTB-predicted redirects (sel=10 accepted)
- flush_cnt_o  out  CNT_WIDTH  count of flushes

Behaviour:
- Reset (synchronous, rst_i=1 at posedge): IF_PC=RESET_PC; ID_valid=0; ID_instr=NOP_INSTR; ID_PC=0; ID_PCplus4=0; ID_btb_hit=0; both counters=0. Reset overrides every other input, including mid-stall and mid-imem-wait.
- Next PC (combinational): 4:1 mux on IF_PCnext_sel_i. Bits [1:0] of the selected value are forced to 00. PC+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0).
- Fetch accept: accept = imem_ready_i & ~ID_stall_i & ~IF_flush_i.
- Per-cycle priority (highest first): reset > flush > stall > imem wait > normal.
- Flush (IF_flush_i=1): IF_PC <= mux output (sel is 01/11 during flush). IF/ID becomes a bubble (valid=0, instr=NOP, btb_hit=0). Flush overrides ID_stall_i and imem_ready_i. flush_cnt increments.
- Stall (ID_stall_i=1, no flush): IF_PC and all IF/ID fields hold.
- imem wait (imem_ready_i=0, no stall, no flush): IF_PC holds. IF/ID loads a bubble so the ID stage drains.
- Normal accept: IF_PC <= mux output. IF/ID <= {1, imem_rdata_i, IF_PC, IF_PC+4, IF_btb_hit_i}. If sel=10, redirect_cnt increments.
- Counters saturate at all-ones and never wrap.
- Latency: an instruction fetched at cycle N appears on ID outputs at cycle N+1. A redirect sampled at cycle N takes effect on IF_PC_o at N+1.
- IF_PC_tag_o, IF_btb_rd_index_o and imem_addr_o are combinational from the IF_PC register.
- Simultaneous stall and flush: flush wins and IF/ID is bubbled. This is required so the mispredicted younger instruction is killed.

Decomposition:
- Shared package fetch_pkg: NOP_INSTR constant; PCSEL_* enum (PCSEL_PLUS4=2'b00, PCSEL_EXMEM_PLUS4=2'b01, PCSEL_BTB=2'b10, PCSEL_EXMEM_TGT=2'b11); if_id_t struct {valid, instr, pc, pcplus4, btb_hit}.
- One sub-module: sat_counter (parameter WIDTH; inputs clk_i, rst_i, inc_i; output cnt_o), instantiated twice.

Test Plan:
- Reset then 3 cycles, ready=1, sel=00, imem returns 32'hA, B, C → IF_PC 0→4→8→C; ID shows (PC 0, instr A), then (4, B), then (8, C), each with valid=1.
- At IF_PC=0x10: sel=10, btb_hit=1, target=0x200 → next IF_PC=0x200; ID_PC=0x10 with ID_btb_hit=1; redirect_cnt=1.
- Flush with sel=11, EXMEM_br_target=0x400, ID_stall=1 in the same cycle → IF_PC=0x400; ID_valid=0, ID_instr=0x13; flush_cnt=1.
- ID_stall=1 for 3 cycles at IF_PC=0x20 → IF_PC and ID fields unchanged for 3 cycles; resume at 0x24 on release.
- imem_ready=0 for 2 cycles at IF_PC=0x30 → PC holds 0x30; ID_valid=0 for 2 cycles; then instr at 0x30 enters ID. Also: IF_PC=0xFFFF_FFFC with sel=00 → wraps to 0. Also: target 0x203 is stored as 0x200.
- Drive 2^CNT_WIDTH+3 flushes → flush_cnt_o stays at all-ones. Assert rst_i during a stall → all outputs take reset values next cycle.
